fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have the following ports: clk  in  1  clock, rising-edge.
REQ-002 The block SHALL have the following port: rst  in  1  reset, asynchronous, active-high.
REQ-003 The block SHALL have the following port: stall  in  1  load-use hold request from the pipeline controller.
REQ-004 The block SHALL have the following port: next_pc_sel  in  1  1 = sequential, 0 = redirect to jb_target (branch taken or jump, resolved in Execute).
REQ-005 The block SHALL have the following port: jb_target  in  32  redirect byte address.
REQ-006 The block SHALL have the following ports: im_addr  out  32  instruction-memory byte address (combinational read, data valid same cycle); im_inst  in  32  fetched instruction.
REQ-007 The block SHALL have the following ports: D_pc  out  32  Decode-stage PC; D_inst  out  32  Decode-stage instruction.
REQ-008 The block SHALL have the following port: D_out  out  24  packed decode word {f7=inst[30], rs2[22:18], rs1[17:13], f3[12:10], rd[9:5], opcode=inst[6:2] at [4:0]}.
REQ-009 The block SHALL have the following ports: D_valid  out  1  Decode holds a real instruction; E_flush  out  1  bubble Execute this cycle; halted  out  1  fetch stopped on ebreak.
REQ-010 The block SHALL have the following port: fetch_count  out  32  count of instructions delivered to Decode.

Function
REQ-011 im_addr SHALL equal F_pc, the internal fetch PC register.
REQ-012 redirect SHALL be defined as (next_pc_sel == 0); E_flush SHALL equal redirect, combinational.
REQ-013 Priority SHALL be: redirect > halt > stall > advance.
REQ-014 On redirect, regardless of stall: F_pc <= {jb_target[31:2],2'b00}, D_inst <= 32'h00000013 (NOP), D_pc <= 0, D_valid <= 0.
REQ-015 On stall without redirect: F_pc, D_inst, D_pc and D_valid SHALL hold.
REQ-016 On advance: F_pc <= F_pc + 4, wrapping modulo 2^32 (32'hFFFFFFFC -> 0); D_inst <= im_inst; D_pc <= F_pc; D_valid <= 1.
REQ-017 D_out SHALL be a combinational decode of D_inst; NOP SHALL decode to 24'h000004.
REQ-018 FSM states SHALL be RUN and HALT.
REQ-019 RUN -> HALT SHALL occur when D_valid=1, D_inst==32'h00100073 (ebreak), no redirect, and no stall.
REQ-020 In HALT: F_pc frozen; D_inst <= NOP; D_valid <= 0; halted=1; next_pc_sel and stall ignored; exit only by rst.
REQ-021 On the transition edge into HALT, the ebreak SHALL leave Decode (bubble inserted), so Execute sees ebreak exactly once.
REQ-022 fetch_count SHALL increment by 1, wrapping, on every clock edge where D_valid is loaded with 1; a held stall SHALL NOT count.
REQ-023 Latency SHALL be as follows: instruction at address A appears on D_inst one edge after im_addr==A with no stall or redirect.

Reset
REQ-024 rst asserted SHALL asynchronously force: F_pc=0, D_inst=NOP, D_pc=0, D_valid=0, state=RUN, fetch_count=0; hence halted=0 and D_out=24'h000004.
REQ-025 rst mid-stall, mid-redirect or in HALT SHALL take the same values; the first edge after deassertion SHALL be a normal fetch from address 0.

Structure
REQ-026 A shared package rv32i_pkg SHALL hold the NOP and EBREAK encodings, the 5-bit opcode constants (R 01100, I 00100, LOAD 00000, JALR 11001, S 01000, B 11000, LUI 01101, AUIPC 00101, JAL 11011), the D_out field offsets, and the fetch state type.
REQ-027 One sub-module, if_id_reg, SHALL hold D_inst, D_pc and D_valid with load/hold/flush controls; the PC, FSM and counter SHALL reside in fetch_unit.

Verification
REQ-028 The bench SHALL cover reset then 3 free-running cycles: im_addr 0,4,8; D_pc 0,4; D_valid 0,1,1; fetch_count 2.
REQ-029 The bench SHALL cover stall held 2 cycles with D_pc=8: D_pc stays 8, im_addr stays 12, fetch_count unchanged, then resumes with D_pc=12.
REQ-030 The bench SHALL cover redirect (next_pc_sel=0, jb_target=32'h103) with stall=1 at the same edge: E_flush=1, next im_addr=32'h100, D_inst=NOP, D_valid=0.
REQ-031 The bench SHALL cover wrap-around with F_pc=32'hFFFFFFFC advancing: next im_addr=0, D_pc=32'hFFFFFFFC.
REQ-032 The bench SHALL cover ebreak in Decode with no redirect: halted=1 next edge, im_addr frozen, D_valid=0; redirect then ignored; rst returns im_addr=0, halted=0.
REQ-033 The bench SHALL cover ebreak in Decode with a simultaneous redirect to 32'h40: no halt, im_addr=32'h40, D_inst=NOP.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings, opcode classes, decode-word layout and fetch FSM state type.
// Pure declarations: no clocked logic, no latency, no flow control.
package rv32i_pkg;

   localparam logic [31:0] INST_NOP    = 32'h0000_0013;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   // inst[6:2] opcode classes
   localparam logic [4:0] OP_R     = 5'b01100;
   localparam logic [4:0] OP_I     = 5'b00100;
   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_JALR  = 5'b11001;
   localparam logic [4:0] OP_S     = 5'b01000;
   localparam logic [4:0] OP_B     = 5'b11000;
   localparam logic [4:0] OP_LUI   = 5'b01101;
   localparam logic [4:0] OP_AUIPC = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b11011;

   localparam int unsigned DOUT_W       = 24;
   localparam int unsigned DOUT_OPC_LSB = 0;
   localparam int unsigned DOUT_RD_LSB  = 5;
   localparam int unsigned DOUT_F3_LSB  = 10;
   localparam int unsigned DOUT_RS1_LSB = 13;
   localparam int unsigned DOUT_RS2_LSB = 18;
   localparam int unsigned DOUT_F7_BIT  = 23;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   // f7 keeps only inst[30]: the one funct7 bit RV32I needs (add/sub, srl/sra).
   function automatic logic [DOUT_W-1:0] decode_word(input logic [31:0] inst);
      logic [DOUT_W-1:0] w;
      w = '0;
      w[DOUT_OPC_LSB +: 5] = inst[6:2];
      w[DOUT_RD_LSB  +: 5] = inst[11:7];
      w[DOUT_F3_LSB  +: 3] = inst[14:12];
      w[DOUT_RS1_LSB +: 5] = inst[19:15];
      w[DOUT_RS2_LSB +: 5] = inst[24:20];
      w[DOUT_F7_BIT]       = inst[30];
      return w;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// Fetch-to-Decode pipeline register: one edge of latency, flush beats load, neither means hold.
// A flush leaves a NOP bubble with pc 0 and valid low.
module if_id_reg
   import rv32i_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        valid
);

   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;

   always_comb begin
      inst_d  = inst_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush) begin
         inst_d  = INST_NOP;
         pc_d    = '0;
         valid_d = 1'b0;
      end else if (load) begin
         inst_d  = in_inst;
         pc_d    = in_pc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_q  <= INST_NOP;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign inst  = inst_q;
   assign pc    = pc_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, IF/ID register, ebreak halt FSM and delivered-instruction counter.
// Instruction at im_addr reaches Decode one edge later; stall holds, redirect flushes and wins over all.
module fetch_unit
   import rv32i_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        next_pc_sel,
   input  logic [31:0] jb_target,
   output logic [31:0] im_addr,
   input  logic [31:0] im_inst,
   output logic [31:0] D_pc,
   output logic [31:0] D_inst,
   output logic [23:0] D_out,
   output logic        D_valid,
   output logic        E_flush,
   output logic        halted,
   output logic [31:0] fetch_count
);

   logic [31:0]  f_pc_q, f_pc_d;
   fetch_state_t state_q, state_d;
   logic         halted_q, halted_d;
   logic [31:0]  count_q, count_d;
   logic         redirect;
   logic         d_load;
   logic         d_flush;
   logic         unused_tgt_bits;

   assign redirect        = ~next_pc_sel;
   assign unused_tgt_bits = ^jb_target[1:0];

   always_comb begin
      f_pc_d   = f_pc_q;
      state_d  = state_q;
      halted_d = halted_q;
      count_d  = count_q;
      d_load   = 1'b0;
      d_flush  = 1'b0;
      case (state_q)
         HALT: begin
            // Frozen until reset; Decode keeps draining bubbles.
            d_flush = 1'b1;
         end
         default: begin
            if (redirect) begin
               f_pc_d  = {jb_target[31:2], 2'b00};
               d_flush = 1'b1;
            end else if (D_valid && (D_inst == INST_EBREAK) && !stall) begin
               // ebreak moves on to Execute once; Decode gets a bubble behind it.
               state_d  = HALT;
               halted_d = 1'b1;
               d_flush  = 1'b1;
            end else if (!stall) begin
               f_pc_d  = f_pc_q + 32'd4;
               d_load  = 1'b1;
               count_d = count_q + 32'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_pc_q   <= '0;
         state_q  <= RUN;
         halted_q <= 1'b0;
         count_q  <= '0;
      end else begin
         f_pc_q   <= f_pc_d;
         state_q  <= state_d;
         halted_q <= halted_d;
         count_q  <= count_d;
      end
   end

   if_id_reg u_if_id (
      .clk     (clk),
      .rst     (rst),
      .load    (d_load),
      .flush   (d_flush),
      .in_inst (im_inst),
      .in_pc   (f_pc_q),
      .inst    (D_inst),
      .pc      (D_pc),
      .valid   (D_valid)
   );

   assign im_addr     = f_pc_q;
   assign E_flush     = redirect;
   assign halted      = halted_q;
   assign fetch_count = count_q;
   assign D_out       = decode_word(D_inst);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference model pushes delivered (pc, inst) pairs to a
// scoreboard on each advance; scenario tasks pop and compare after the edge, plus direct checks.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        next_pc_sel;
   logic [31:0] jb_target;
   logic [31:0] im_addr;
   logic [31:0] im_inst;
   logic [31:0] D_pc;
   logic [31:0] D_inst;
   logic [23:0] D_out;
   logic        D_valid;
   logic        E_flush;
   logic        halted;
   logic [31:0] fetch_count;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_t;

   fetch_t      sb[$];
   fetch_t      e;
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [31:0] ebreak_at;

   logic [31:0] m_fpc, m_dinst, m_cnt;
   logic        m_dvalid, m_halt;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .next_pc_sel (next_pc_sel),
      .jb_target   (jb_target),
      .im_addr     (im_addr),
      .im_inst     (im_inst),
      .D_pc        (D_pc),
      .D_inst      (D_inst),
      .D_out       (D_out),
      .D_valid     (D_valid),
      .E_flush     (E_flush),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a, input logic [31:0] eb);
      if (a == eb) return EBREAK;
      return ((a * 32'h9E37_79B1) & 32'hFFFF_FF80) | 32'h0000_0033;
   endfunction

   function automatic logic [23:0] ref_dout(input logic [31:0] i);
      return {i[30], i[24:20], i[19:15], i[14:12], i[11:7], i[6:2]};
   endfunction

   always_comb im_inst = inst_of(im_addr, ebreak_at);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_fpc    = 32'h0;
      m_dinst  = NOP;
      m_cnt    = 32'h0;
      m_dvalid = 1'b0;
      m_halt   = 1'b0;
      sb.delete();
   endtask

   task automatic set_in(input logic s, input logic sel, input logic [31:0] t);
      stall       = s;
      next_pc_sel = sel;
      jb_target   = t;
   endtask

   // One clock edge with the current inputs; the model follows and checks happen at edge+1.
   task automatic tick();
      logic        s, sel;
      logic [31:0] t;
      fetch_t      p;
      s   = stall;
      sel = next_pc_sel;
      t   = jb_target;
      @(posedge clk);
      if (m_halt) begin
         m_dvalid = 1'b0;
         m_dinst  = NOP;
      end else if (!sel) begin
         m_fpc    = {t[31:2], 2'b00};
         m_dvalid = 1'b0;
         m_dinst  = NOP;
      end else if (m_dvalid && m_dinst == EBREAK && !s) begin
         m_halt   = 1'b1;
         m_dvalid = 1'b0;
         m_dinst  = NOP;
      end else if (!s) begin
         p.pc     = m_fpc;
         p.inst   = inst_of(m_fpc, ebreak_at);
         sb.push_back(p);
         m_dinst  = p.inst;
         m_dvalid = 1'b1;
         m_fpc    = m_fpc + 32'd4;
         m_cnt    = m_cnt + 32'd1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      ebreak_at = 32'h1;
      set_in(1'b0, 1'b1, 32'h0);
      model_reset();
      #12;
      total_cnt++; if (im_addr !== 32'h0) $display("FAIL rst_im_addr: got %h want 0", im_addr); else pass_cnt++;
      total_cnt++; if (D_inst !== NOP) $display("FAIL rst_d_inst: got %h want %h", D_inst, NOP); else pass_cnt++;
      total_cnt++; if (D_out !== 24'h000004) $display("FAIL rst_d_out: got %h want 000004", D_out); else pass_cnt++;
      total_cnt++; if ({D_valid, halted} !== 2'b00) $display("FAIL rst_valid_halted: got %b want 00", {D_valid, halted}); else pass_cnt++;
      total_cnt++; if (D_pc !== 32'h0 || fetch_count !== 32'h0) $display("FAIL rst_pc_count: got %h/%h want 0/0", D_pc, fetch_count); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      set_in(1'b0, 1'b1, 32'h0);
      total_cnt++; if (E_flush !== 1'b0) $display("FAIL run_e_flush: got %b want 0", E_flush); else pass_cnt++;
      tick();
      total_cnt++; if (im_addr !== 32'h4 || D_valid !== 1'b1) $display("FAIL run_edge1: got addr %h valid %b want 4 1", im_addr, D_valid); else pass_cnt++;
      total_cnt++;
      if (sb.size() == 0) $display("FAIL run_sb1: scoreboard empty");
      else begin e = sb.pop_front(); if (D_pc !== e.pc || D_inst !== e.inst || D_pc !== 32'h0) $display("FAIL run_sb1: got %h/%h want %h/%h", D_pc, D_inst, e.pc, e.inst); else pass_cnt++; end
      tick();
      total_cnt++; if (im_addr !== 32'h8 || D_valid !== 1'b1) $display("FAIL run_edge2: got addr %h valid %b want 8 1", im_addr, D_valid); else pass_cnt++;
      total_cnt++;
      if (sb.size() == 0) $display("FAIL run_sb2: scoreboard empty");
      else begin e = sb.pop_front(); if (D_pc !== e.pc || D_inst !== e.inst || D_pc !== 32'h4) $display("FAIL run_sb2: got %h/%h want %h/%h", D_pc, D_inst, e.pc, e.inst); else pass_cnt++; end
      total_cnt++; if (fetch_count !== 32'd2) $display("FAIL run_count: got %0d want 2", fetch_count); else pass_cnt++;
      tick();
      total_cnt++;
      if (sb.size() == 0) $display("FAIL run_sb3: scoreboard empty");
      else begin e = sb.pop_front(); if (D_pc !== e.pc || D_inst !== e.inst || D_pc !== 32'h8) $display("FAIL run_sb3: got %h/%h want %h/%h", D_pc, D_inst, e.pc, e.inst); else pass_cnt++; end
   endtask

   task automatic test_stall();
      set_in(1'b1, 1'b1, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         total_cnt++;
         if (D_pc !== 32'h8 || im_addr !== 32'hC || D_valid !== 1'b1 || fetch_count !== 32'd3)
            $display("FAIL stall_hold%0d: got pc %h addr %h valid %b cnt %0d want 8 c 1 3", i, D_pc, im_addr, D_valid, fetch_count);
         else pass_cnt++;
      end
      set_in(1'b0, 1'b1, 32'h0);
      tick();
      total_cnt++;
      if (sb.size() == 0) $display("FAIL stall_resume: scoreboard empty");
      else begin e = sb.pop_front(); if (D_pc !== e.pc || D_inst !== e.inst || D_pc !== 32'hC) $display("FAIL stall_resume: got %h/%h want %h/%h", D_pc, D_inst, e.pc, e.inst); else pass_cnt++; end
      total_cnt++; if (fetch_count !== m_cnt) $display("FAIL stall_count: got %0d want %0d", fetch_count, m_cnt); else pass_cnt++;
   endtask

   task automatic test_redirect();
      set_in(1'b1, 1'b0, 32'h0000_0103);
      #1;
      total_cnt++; if (E_flush !== 1'b1) $display("FAIL redir_e_flush: got %b want 1", E_flush); else pass_cnt++;
      tick();
      total_cnt++; if (im_addr !== 32'h100) $display("FAIL redir_addr: got %h want 100", im_addr); else pass_cnt++;
      total_cnt++;
      if (D_inst !== NOP || D_valid !== 1'b0 || D_pc !== 32'h0 || D_out !== 24'h000004)
         $display("FAIL redir_bubble: got inst %h valid %b pc %h out %h want NOP 0 0 000004", D_inst, D_valid, D_pc, D_out);
      else pass_cnt++;
      total_cnt++; if (fetch_count !== m_cnt) $display("FAIL redir_count: got %0d want %0d", fetch_count, m_cnt); else pass_cnt++;
      set_in(1'b0, 1'b1, 32'h0);
      tick();
      total_cnt++;
      if (sb.size() == 0) $display("FAIL redir_target: scoreboard empty");
      else begin e = sb.pop_front(); if (D_pc !== e.pc || D_inst !== e.inst || D_pc !== 32'h100) $display("FAIL redir_target: got %h/%h want %h/%h", D_pc, D_inst, e.pc, e.inst); else pass_cnt++; end
   endtask

   task automatic test_wrap();
      set_in(1'b0, 1'b0, 32'hFFFF_FFFC);
      tick();
      total_cnt++; if (im_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got %h want fffffffc", im_addr); else pass_cnt++;
      set_in(1'b0, 1'b1, 32'h0);
      tick();
      total_cnt++; if (im_addr !== 32'h0) $display("FAIL wrap_addr: got %h want 0", im_addr); else pass_cnt++;
      total_cnt++;
      if (sb.size() == 0) $display("FAIL wrap_dpc: scoreboard empty");
      else begin
         e = sb.pop_front();
         if (D_pc !== e.pc || D_inst !== e.inst || D_pc !== 32'hFFFF_FFFC || D_out !== ref_dout(e.inst))
            $display("FAIL wrap_dpc: got %h/%h out %h want %h/%h out %h", D_pc, D_inst, D_out, e.pc, e.inst, ref_dout(e.inst));
         else pass_cnt++;
      end
   endtask

   task automatic test_ebreak_redirect();
      ebreak_at = 32'h200;
      set_in(1'b0, 1'b0, 32'h200);
      tick();
      set_in(1'b0, 1'b1, 32'h0);
      tick();
      total_cnt++;
      if (sb.size() == 0) $display("FAIL ebr_load: scoreboard empty");
      else begin e = sb.pop_front(); if (D_pc !== e.pc || D_inst !== e.inst || D_inst !== EBREAK) $display("FAIL ebr_load: got %h/%h want %h/%h", D_pc, D_inst, e.pc, e.inst); else pass_cnt++; end
      set_in(1'b0, 1'b0, 32'h40);
      tick();
      total_cnt++;
      if (halted !== 1'b0 || im_addr !== 32'h40 || D_inst !== NOP)
         $display("FAIL ebr_redirect: got halted %b addr %h inst %h want 0 40 NOP", halted, im_addr, D_inst);
      else pass_cnt++;
      set_in(1'b0, 1'b1, 32'h0);
      tick();
      total_cnt++;
      if (sb.size() == 0) $display("FAIL ebr_after: scoreboard empty");
      else begin e = sb.pop_front(); if (D_pc !== e.pc || D_inst !== e.inst || halted !== 1'b0) $display("FAIL ebr_after: got %h/%h halted %b want %h/%h 0", D_pc, D_inst, halted, e.pc, e.inst); else pass_cnt++; end
   endtask

   task automatic test_halt();
      set_in(1'b0, 1'b0, 32'h200);
      tick();
      set_in(1'b0, 1'b1, 32'h0);
      tick();
      total_cnt++;
      if (sb.size() == 0) $display("FAIL halt_load: scoreboard empty");
      else begin e = sb.pop_front(); if (D_pc !== e.pc || D_inst !== EBREAK) $display("FAIL halt_load: got %h/%h want %h/%h", D_pc, D_inst, e.pc, EBREAK); else pass_cnt++; end
      set_in(1'b1, 1'b1, 32'h0);
      tick();
      total_cnt++;
      if (halted !== 1'b0 || D_inst !== EBREAK || im_addr !== 32'h204)
         $display("FAIL halt_stalled: got halted %b inst %h addr %h want 0 ebreak 204", halted, D_inst, im_addr);
      else pass_cnt++;
      set_in(1'b0, 1'b1, 32'h0);
      tick();
      total_cnt++;
      if (halted !== 1'b1 || im_addr !== 32'h204 || D_valid !== 1'b0 || D_inst !== NOP)
         $display("FAIL halt_enter: got halted %b addr %h valid %b inst %h want 1 204 0 NOP", halted, im_addr, D_valid, D_inst);
      else pass_cnt++;
      set_in(1'b0, 1'b0, 32'h80);
      tick();
      set_in(1'b1, 1'b1, 32'h0);
      tick();
      total_cnt++;
      if (halted !== 1'b1 || im_addr !== 32'h204 || D_valid !== 1'b0 || fetch_count !== m_cnt)
         $display("FAIL halt_ignore: got halted %b addr %h valid %b cnt %0d want 1 204 0 %0d", halted, im_addr, D_valid, fetch_count, m_cnt);
      else pass_cnt++;
      set_in(1'b0, 1'b1, 32'h0);
      rst = 1'b1;
      #2;
      total_cnt++;
      if (im_addr !== 32'h0 || halted !== 1'b0 || D_out !== 24'h000004 || fetch_count !== 32'h0)
         $display("FAIL halt_rst: got addr %h halted %b out %h cnt %0d want 0 0 000004 0", im_addr, halted, D_out, fetch_count);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      tick();
      total_cnt++;
      if (sb.size() == 0) $display("FAIL halt_refetch: scoreboard empty");
      else begin e = sb.pop_front(); if (D_pc !== 32'h0 || D_inst !== e.inst || im_addr !== 32'h4) $display("FAIL halt_refetch: got pc %h inst %h addr %h want 0 %h 4", D_pc, D_inst, im_addr, e.inst); else pass_cnt++; end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_redirect();
      test_wrap();
      test_ebreak_redirect();
      test_halt();
      total_cnt++; if (sb.size() != 0) $display("FAIL sb_drain: %0d entries left want 0", sb.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
